pc_next_reg: RTL and testbench



---
 rtl/pc_next_reg.sv | 103 ++++++++++
 tb/tb_pc_next_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_next_reg.sv
// Registered next-PC select with a one-deep redirect buffer for stalls.
// Optional target alignment check: define PC_ALIGN_CHECK_EN.
module pc_next_reg #(
  parameter int                 WIDTH    = 32,
  parameter int                 NUM_SRC  = 5,
  parameter int                 SEL_W    = 3,
  parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0]   TRAP_VEC = 32'h0000_00FC
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_flat,
  input  logic [SEL_W-1:0]         pc_source,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_true,
  input  logic                     stall,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         pc_prev,
  output logic                     redirect_pending,
  output logic                     sel_err,
  output logic                     align_err
);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] buf_q;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] tgt;
  logic             req;
  logic             sel_bad;
  logic             mis;

  assign req = pc_write | (pc_write_cond & cond_true);

  always_comb begin
    raw     = TRAP_VEC;
    sel_bad = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pc_source == SEL_W'(k)) begin
        raw     = src_flat[k*WIDTH +: WIDTH];
        sel_bad = 1'b0;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // a bad index already forces the trap, so it masks the alignment fault
  assign mis = !sel_bad && (raw[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign tgt = mis ? TRAP_VEC : raw;
  assign redirect_pending = (state == PEND);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc_out  <= RESET_PC;
      pc_prev <= RESET_PC;
      buf_q   <= '0;
      sel_err <= 1'b0;
    end else begin
      sel_err <= req & sel_bad;
      unique case (state)
        IDLE: begin
          if (req && stall) begin
            buf_q <= tgt;
            state <= PEND;
          end else if (req) begin
            pc_prev <= pc_out;
            pc_out  <= tgt;
          end
        end
        PEND: begin
          if (stall) begin
            if (req) buf_q <= tgt;
          end else begin
            pc_prev <= pc_out;
            pc_out  <= req ? tgt : buf_q;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) align_err <= 1'b0;
    else          align_err <= req & mis;
  end
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_reg.sv
// Directed bench for pc_next_reg; expectations follow the
// PC_ALIGN_CHECK_EN setting of the build.
module tb_pc_next_reg;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [159:0] src_flat;
  logic [2:0]   pc_source;
  logic         pc_write;
  logic         pc_write_cond;
  logic         cond_true;
  logic         stall;
  logic [31:0]  pc_out;
  logic [31:0]  pc_prev;
  logic         redirect_pending;
  logic         sel_err;
  logic         align_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_next_reg dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .src_flat         (src_flat),
    .pc_source        (pc_source),
    .pc_write         (pc_write),
    .pc_write_cond    (pc_write_cond),
    .cond_true        (cond_true),
    .stall            (stall),
    .pc_out           (pc_out),
    .pc_prev          (pc_prev),
    .redirect_pending (redirect_pending),
    .sel_err          (sel_err),
    .align_err        (align_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] exp_prev;
    logic        exp_al;
    reset_n       = 1'b0;
    src_flat      = {32'h500, 32'h400, 32'h300, 32'h200, 32'h100};
    pc_source     = 3'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    cond_true     = 1'b0;
    stall         = 1'b0;
    #3;
    chk("rst_pc",   pc_out, 32'h0);
    chk("rst_prev", pc_prev, 32'h0);
    chk("rst_pend", 32'(redirect_pending), 32'h0);
    chk("rst_sel",  32'(sel_err), 32'h0);
    chk("rst_al",   32'(align_err), 32'h0);
    #7;
    reset_n = 1'b1;

    pc_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_source = 3'(i);
      step();
      chk("seq_pc",   pc_out, 32'h100 * (i + 1));
      chk("seq_prev", pc_prev, 32'h100 * i);
    end

    pc_write      = 1'b0;
    pc_write_cond = 1'b1;
    pc_source     = 3'd1;
    cond_true     = 1'b0;
    step();
    chk("cond0_pc", pc_out, 32'h500);
    cond_true = 1'b1;
    step();
    chk("cond1_pc",   pc_out, 32'h200);
    chk("cond1_prev", pc_prev, 32'h500);
    pc_write_cond = 1'b0;
    cond_true     = 1'b0;

    stall     = 1'b1;
    pc_write  = 1'b1;
    pc_source = 3'd2;
    step();
    chk("stl_a_pend", 32'(redirect_pending), 32'h1);
    chk("stl_a_pc",   pc_out, 32'h200);
    pc_source = 3'd3;
    step();
    chk("stl_b_pend", 32'(redirect_pending), 32'h1);
    chk("stl_b_pc",   pc_out, 32'h200);
    stall    = 1'b0;
    pc_write = 1'b0;
    step();
    chk("rel_pc",   pc_out, 32'h400);
    chk("rel_prev", pc_prev, 32'h200);
    chk("rel_pend", 32'(redirect_pending), 32'h0);

    pc_write  = 1'b1;
    pc_source = 3'd7;
    step();
    chk("sel_pc",  pc_out, 32'hFC);
    chk("sel_err", 32'(sel_err), 32'h1);
    chk("sel_al",  32'(align_err), 32'h0);
    pc_write = 1'b0;
    step();
    chk("sel_off", 32'(sel_err), 32'h0);
    chk("sel_hold", pc_out, 32'hFC);

`ifdef PC_ALIGN_CHECK_EN
    exp_pc = 32'hFC;
    exp_al = 1'b1;
`else
    exp_pc = 32'h102;
    exp_al = 1'b0;
`endif
    src_flat[31:0] = 32'h102;
    pc_write  = 1'b1;
    pc_source = 3'd0;
    step();
    chk("al_pc",  pc_out, exp_pc);
    chk("al_err", 32'(align_err), 32'(exp_al));
    chk("al_sel", 32'(sel_err), 32'h0);
    exp_prev = exp_pc;
    pc_write = 1'b0;
    step();
    chk("al_off", 32'(align_err), 32'h0);

    stall     = 1'b1;
    pc_write  = 1'b1;
    pc_source = 3'd2;
    step();
    chk("live_pend", 32'(redirect_pending), 32'h1);
    stall     = 1'b0;
    pc_source = 3'd4;
    step();
    chk("live_pc",   pc_out, 32'h500);
    chk("live_prev", pc_prev, exp_prev);
    chk("live_pend0", 32'(redirect_pending), 32'h0);

    stall     = 1'b1;
    pc_source = 3'd1;
    step();
    chk("rp_pend", 32'(redirect_pending), 32'h1);
    pc_write = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pc",   pc_out, 32'h0);
    chk("arst_prev", pc_prev, 32'h0);
    chk("arst_pend", 32'(redirect_pending), 32'h0);
    #2;
    reset_n = 1'b1;
    stall   = 1'b0;
    step();
    chk("arst_drop", pc_out, 32'h0);
    chk("arst_idle", 32'(redirect_pending), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
